cpu_trace_tx: RTL and testbench

//  Hardware trace transmitter for cpu_top; the on-chip producer of the per-instruction state the simulation bench prints.
//  On each trace_strobe it snapshots PC, instruction, regA, regB, ALU result and flags into a small record FIFO.
//  It drains the FIFO as 7-byte records on a UART-format serial line (tx), so a board run yields the same trace as simulation.
//  It sits beside cpu_top in the top level and is fed directly from cpu_top internal nets.

---
 rtl/cpu_trace_tx_pkg.sv | 23 ++
 rtl/cpu_trace_tx_fifo.sv | 54 +++++
 rtl/cpu_trace_tx.sv | 107 ++++++++++
 tb/tb_cpu_trace_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_tx_pkg.sv
// Shared constants, FSM encoding and record byte selection for the CPU trace transmitter.
package cpu_trace_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         REC_BYTES = 7;
    localparam int         REC_W     = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Byte 0 is the sync marker; bytes 1..6 walk the record from its MSB down.
    function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec, input logic [2:0] idx);
        logic [REC_W-1:0] sh;
        if (idx == 3'd0) return SYNC_BYTE;
        sh = rec >> (8 * (REC_BYTES - 1 - int'(idx)));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/cpu_trace_tx_fifo.sv
// Synchronous record FIFO; read data is registered on pop (no fall-through).
module trace_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_accept,
    output logic         o_nempty_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] r_wp, r_rp;
    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_rdata;
    logic [CW-1:0] w_count, w_count_nxt;
    logic          w_full, w_rd, w_wr;

    assign w_count     = r_wp - r_rp;
    assign o_empty     = (w_count == '0);
    assign w_full      = (w_count == CW'(DEPTH));
    assign w_rd        = i_pop && !o_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_wr        = i_push && (!w_full || w_rd);
    assign w_count_nxt = w_count + CW'(w_wr) - CW'(w_rd);
    assign o_accept     = w_wr;
    assign o_nempty_nxt = (w_count_nxt != '0);
    assign o_rdata      = r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) begin
                r_rp    <= r_rp + 1'b1;
                r_rdata <= r_mem[r_rp[AW-1:0]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/cpu_trace_tx.sv
// Captures per-instruction CPU state on a strobe and serialises each record as 7 UART bytes.
module cpu_trace_tx
    import cpu_trace_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_trace_strobe,
    input  logic [7:0] i_pc,
    input  logic [7:0] i_instrucao,
    input  logic [7:0] i_reg_a,
    input  logic [7:0] i_reg_b,
    input  logic [7:0] i_alu_result,
    input  logic       i_alu_zero,
    input  logic       i_alu_eq,
    output logic       o_tx,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt
);
    localparam int BW = $clog2(CLK_DIV);

    tx_state_t        r_state, w_state_nxt;
    logic [BW-1:0]    r_baud;
    logic [2:0]       r_bit;
    logic [2:0]       r_byte;
    logic             r_tx, r_busy;
    logic [7:0]       r_drop;
    logic [REC_W-1:0] w_snap, w_hold;
    logic             w_pop, w_empty, w_accept, w_nempty_nxt, w_bit_end;
    logic [7:0]       w_byte;

    assign w_snap = {i_pc, i_instrucao, i_reg_a, i_reg_b, i_alu_result,
                     6'b0, i_alu_zero, i_alu_eq};

    // The FIFO's registered read port doubles as the record holder until the next pop.
    trace_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (i_trace_strobe),
        .i_wdata      (w_snap),
        .i_pop        (w_pop),
        .o_rdata      (w_hold),
        .o_empty      (w_empty),
        .o_accept     (w_accept),
        .o_nempty_nxt (w_nempty_nxt)
    );

    assign w_bit_end = (r_baud == BW'(CLK_DIV - 1));
    assign w_byte    = rec_byte(w_hold, r_byte);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_START;
            end
            ST_START: if (w_bit_end) w_state_nxt = ST_DATA;
            ST_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = ST_STOP;
            ST_STOP:  if (w_bit_end)
                w_state_nxt = (r_byte == 3'(REC_BYTES - 1)) ? ST_IDLE : ST_START;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_baud <= '0;
            r_bit  <= '0;
            r_byte <= '0;
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_drop <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_baud <= '0;
                r_bit  <= '0;
                r_byte <= '0;
            end else begin
                r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
                if (r_state == ST_DATA && w_bit_end) r_bit  <= r_bit + 1'b1;
                if (r_state == ST_STOP && w_bit_end) r_byte <= r_byte + 1'b1;
            end
            // Line output trails the state by one cycle, giving the strobe->start latency of 2.
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= w_byte[r_bit];
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= w_nempty_nxt || (w_state_nxt != ST_IDLE);
            if (i_trace_strobe && !w_accept && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_cpu_trace_tx.sv
// Directed bench: scoreboard of expected bytes against a mid-bit UART decoder on tx.
module tb_cpu_trace_tx;
    localparam int D  = 4;
    localparam int FD = 4;

    logic       clk = 1'b0, rst = 1'b1, stb = 1'b0;
    logic [7:0] pc = '0, ins = '0, ra = '0, rb = '0, alu = '0;
    logic       z = 1'b0, e = 1'b0;
    logic       tx, busy;
    logic [7:0] drop;

    cpu_trace_tx #(.CLK_DIV(D), .FIFO_DEPTH(FD)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_trace_strobe (stb),
        .i_pc           (pc),
        .i_instrucao    (ins),
        .i_reg_a        (ra),
        .i_reg_b        (rb),
        .i_alu_result   (alu),
        .i_alu_zero     (z),
        .i_alu_eq       (e),
        .o_tx           (tx),
        .o_busy         (busy),
        .o_drop_cnt     (drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    logic [8:0] rx_q[$];
    int         rx_t[$];

    // Mid-bit decoder: start seen at 0.5 cycle, then samples at 1.5 cycles into each bit.
    initial begin : decoder
        logic [7:0] b;
        logic       ab;
        int         t0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                t0 = cyc;
                ab = 1'b0;
                @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (D) @(negedge clk);
                    if (rst) ab = 1'b1;
                    b[k] = tx;
                end
                repeat (D) @(negedge clk);
                if (rst) ab = 1'b1;
                if (!ab) begin
                    rx_q.push_back({tx, b});
                    rx_t.push_back(t0);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_strobe(input logic [7:0] p, i, a, b, al, input logic zz, ee, input bit push);
        @(negedge clk);
        pc = p; ins = i; ra = a; rb = b; alu = al; z = zz; e = ee; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        if (push) begin
            exp_q.push_back(8'hA5); exp_q.push_back(p);  exp_q.push_back(i);
            exp_q.push_back(a);     exp_q.push_back(b);  exp_q.push_back(al);
            exp_q.push_back({6'b0, zz, ee});
        end
    endtask

    task automatic clear_rx();
        exp_q.delete(); rx_q.delete(); rx_t.delete();
    endtask

    task automatic drain(input string tag);
        int         n;
        logic [7:0] eb;
        logic [8:0] r;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        chk({tag, "_drain_timeout"}, int'(n < 5000), 1);
        repeat (20) @(negedge clk);
        chk({tag, "_byte_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            eb = exp_q.pop_front();
            r  = rx_q.pop_front();
            chk({tag, "_byte"}, int'(r[7:0]), int'(eb));
            chk({tag, "_stop"}, int'(r[8]), 1);
        end
        exp_q.delete(); rx_q.delete();
    endtask

    initial begin : main
        int ts, n, bad, w;

        // Test 1: reset state held while idle
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop), 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || drop !== 8'h00) bad++;
        end
        chk("idle_100", bad, 0);

        // Test 2: single record, latency and busy duration
        clear_rx();
        do_strobe(8'h12, 8'h3C, 8'h05, 8'h07, 8'h0C, 1'b0, 1'b0, 1'b1);
        ts = cyc;
        @(negedge clk);
        chk("t2_busy_rise", int'(busy), 1);
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        chk("t2_busy_fall", cyc - ts, 281);
        repeat (10) @(negedge clk);
        chk("t2_latency", (rx_t.size() > 0) ? rx_t[0] - ts : -1, 2);
        drain("t2");

        // Test 3: flags byte and bit time
        clear_rx();
        do_strobe(8'h40, 8'h81, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        w = 0;
        while (tx === 1'b0 && w < 50) begin @(negedge clk); w++; end
        chk("t3_bit_time", w, D);
        drain("t3");

        // Test 4: burst of 6 strobes, one dropped; order and inter-record gap
        clear_rx();
        for (int i = 0; i < 6; i++)
            do_strobe(8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3), 8'(16 * i + 4),
                      8'(16 * i + 5), i[0], i[1], i < 5);
        @(negedge clk);
        chk("t4_drop", int'(drop), 1);
        drain("t4");
        chk("t4_rec_cnt", rx_t.size(), 35);
        if (rx_t.size() >= 35) begin
            chk("t4_byte_gap", rx_t[1] - rx_t[0], 10 * D);
            for (int k = 0; k < 4; k++)
                chk("t4_rec_gap", rx_t[7 * k + 7] - rx_t[7 * k], 70 * D + 1);
        end

        // Test 5: drop counter saturation
        for (int i = 0; i < 300; i++)
            do_strobe(8'(i), 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_drop_sat", int'(drop), 8'hFF);
        chk("t5_busy", int'(busy), 1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_rst_drop", int'(drop), 0);
        chk("t5_rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);

        // Test 6: reset in the middle of byte 3, then a clean record
        clear_rx();
        do_strobe(8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h12, 1'b1, 1'b0, 1'b0);
        ts = cyc;
        n = 0;
        while (cyc < ts + 2 + 3 * 10 * D + D + 2 * D && n < 1000) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tx", int'(tx), 1);
        chk("t6_rst_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_idle_tx", int'(tx), 1);
        clear_rx();
        do_strobe(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 1'b0, 1'b1, 1'b1);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
